// File: rtl/n2t_pkg.sv
// n2t_pkg: shared word width and word type for the Hack-style datapath
package n2t_pkg;
    localparam int N2T_WORD_W = 16;
    typedef logic [N2T_WORD_W-1:0] n2t_word_t;
endpackage

// File: rtl/n2t_mux_bit.sv
// n2t_mux_bit: one-bit two-input mux built from nand gates
module n2t_mux_bit (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic out
);
    logic sel_n, a_t, b_t, ab_t;
    nand g_inv (sel_n, sel, sel);
    nand g_a   (a_t, a, sel_n);
    nand g_b   (b_t, b, sel);
    // consensus term keeps out resolved when sel is unknown but a == b
    nand g_ab  (ab_t, a, b);
    nand g_or  (out, a_t, b_t, ab_t);
endmodule

// File: rtl/n2t_mux16.sv
// n2t_mux16: word-wide gate-level mux with a registered copy of the selected word
module n2t_mux16
    import n2t_pkg::*;
#(
    parameter int WIDTH = N2T_WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q
);
    logic [WIDTH-1:0] out_d;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        n2t_mux_bit u_bit (
            .a   (a[i]),
            .b   (b[i]),
            .sel (sel),
            .out (out[i])
        );
    end
    always_comb out_d = reset ? '0 : out;
    always_ff @(posedge clk) out_q <= out_d;
endmodule

// File: tb/tb_n2t_mux16.sv
// tb_n2t_mux16: directed and random self-checking bench for n2t_mux16
module tb_n2t_mux16;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] a_v, b, a_in, out, out_q, hold_q, exp_w, prev_w;
    logic        sel, loop_en;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    // external hold register closing the loop out -> a
    always_ff @(posedge clk) hold_q <= out;
    assign a_in = loop_en ? hold_q : a_v;

    n2t_mux16 dut (
        .clk   (clk),
        .reset (reset),
        .a     (a_in),
        .b     (b),
        .sel   (sel),
        .out   (out),
        .out_q (out_q)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        loop_en = 1'b0;
        reset = 1'b1;
        a_v = 16'h0F0F;
        b = 16'hF0F0;
        sel = 1'b0;
        #1 check("out_during_reset", out, 16'h0F0F);
        step();
        check("reset_out_q", out_q, 16'h0000);
        reset = 1'b0;
        a_v = 16'h1234; b = 16'hABCD; sel = 1'b0;
        #1 check("sel_a_out", out, 16'h1234);
        step();
        check("sel_a_out_q", out_q, 16'h1234);
        sel = 1'b1;
        #1 check("sel_b_out", out, 16'hABCD);
        check("sel_b_out_q_unchanged", out_q, 16'h1234);
        step();
        check("sel_b_out_q", out_q, 16'hABCD);
        a_v = 16'hFFFF; b = 16'h0000; sel = 1'b0;
        #1 check("ones_sel0", out, 16'hFFFF);
        sel = 1'b1;
        #1 check("zeros_sel1", out, 16'h0000);
        a_v = 16'h5555; b = 16'hAAAA; sel = 1'b0;
        #1 check("alt_sel0", out, 16'h5555);
        sel = 1'b1;
        #1 check("alt_sel1", out, 16'hAAAA);
        step();
        check("alt_out_q", out_q, 16'hAAAA);
        reset = 1'b1; b = 16'hBEEF;
        #1 check("reset_out_comb", out, 16'hBEEF);
        step();
        check("reset_priority", out_q, 16'h0000);
        reset = 1'b0;
        step();
        check("reset_release", out_q, 16'hBEEF);
        loop_en = 1'b1; sel = 1'b1; b = 16'h00FF;
        #1 check("loop_load", out, 16'h00FF);
        step();
        sel = 1'b0; b = 16'h1111;
        #1 check("loop_hold0", out, 16'h00FF);
        step();
        check("loop_hold1", out, 16'h00FF);
        check("loop_hold_q", out_q, 16'h00FF);
        step();
        check("loop_hold2", out, 16'h00FF);
        loop_en = 1'b0;
        prev_w = out;
        for (int i = 0; i < 1000; i++) begin
            a_v = 16'($urandom);
            b = 16'($urandom);
            sel = 1'($urandom);
            exp_w = sel ? b : a_v;
            #1 check("rand_out", out, exp_w);
            step();
            check("rand_out_q", out_q, exp_w);
            prev_w = exp_w;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
